// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states, field widths
// and the decoded instruction field bundle used by the ROM and decode sides.
package fetch_sequencer_pkg;

  localparam int OPC_W = 4;
  localparam int OPR_W = 3;
  localparam int IMM_W = 8;
  localparam int PC_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic             format;
    logic [OPC_W-1:0] opcode;
    logic             sign;
    logic [OPR_W-1:0] operand;
    logic [IMM_W-1:0] immediate;
  } instr_fields_t;

  // Sign-extend the 8-bit immediate to a PC-wide offset.
  function automatic logic [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next_calc.sv
// Combinational next-PC selection: sequential increment with wrap, branch
// target (relative or absolute) and the end-of-program compare.
module pc_next_calc
  import fetch_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] PROG_END = 16'd34
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  ir_pc,
  input  logic [IMM_W-1:0] ir_immediate,
  input  logic             take_branch,
  input  logic             branch_rel,
  input  logic [PC_W-1:0]  branch_target,
  output logic [PC_W-1:0]  next_pc,
  output logic             at_end
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] branch_pc;

  // Increment wraps 16'hFFFF to 16'h0000 through natural modular overflow.
  assign pc_inc = pc + 16'd1;
  assign at_end = (pc == PROG_END);

  // Branch destination and final next-PC choice.
  always_comb begin
    branch_pc = branch_target;
    next_pc   = pc;
    if (branch_rel) begin
      branch_pc = ir_pc + sext_imm(ir_immediate);
    end else begin
      branch_pc = branch_target;
    end
    if (take_branch) begin
      next_pc = branch_pc;
    end else if (at_end) begin
      next_pc = pc;
    end else begin
      next_pc = pc_inc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC into a combinational instruction ROM and
// latches the decoded fields into an instruction register for execute.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] START_PC = 16'd0,
  parameter logic [15:0] PROG_END = 16'd34,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_en,
  input  logic             branch_rel,
  input  logic [15:0]      branch_target,
  input  logic             rom_format,
  input  logic [3:0]       rom_opcode,
  input  logic             rom_sign,
  input  logic [2:0]       rom_operand,
  input  logic [7:0]       rom_immediate,
  output logic [15:0]      pc_out,
  output logic             ir_valid,
  output logic [15:0]      ir_pc,
  output logic             ir_format,
  output logic [3:0]       ir_opcode,
  output logic             ir_sign,
  output logic [2:0]       ir_operand,
  output logic [7:0]       ir_immediate,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t        state, state_nxt;
  instr_fields_t ir, ir_nxt;
  instr_fields_t rom_fields;
  logic [15:0]      pc_nxt;
  logic [15:0]      ir_pc_nxt;
  logic             ir_valid_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             take_branch;
  logic [15:0]      next_pc;
  logic             at_end;

  assign rom_fields = {rom_format, rom_opcode, rom_sign, rom_operand, rom_immediate};

  // A branch only redirects when nothing of higher priority is active and the IR is live.
  assign take_branch = (state == RUN) && !halt_req && !stall && branch_en && ir_valid;

  pc_next_calc #(
    .PROG_END(PROG_END)
  ) u_pc_next_calc (
    .pc           (pc_out),
    .ir_pc        (ir_pc),
    .ir_immediate (ir.immediate),
    .take_branch  (take_branch),
    .branch_rel   (branch_rel),
    .branch_target(branch_target),
    .next_pc      (next_pc),
    .at_end       (at_end)
  );

  // Next-state and next-register values; everything holds unless a case updates it.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_out;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_valid_nxt = ir_valid;
    count_nxt    = instr_count;
    case (state)
      IDLE, HALTED: begin
        ir_valid_nxt = 1'b0;
        if (start) begin
          pc_nxt    = START_PC;
          count_nxt = '0;
          state_nxt = RUN;
        end else begin
          state_nxt = state;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_nxt    = HALTED;
          ir_valid_nxt = 1'b0;
        end else if (stall) begin
          ir_valid_nxt = ir_valid;
        end else if (take_branch) begin
          // The fetch at pc_out is squashed, leaving a one-cycle bubble.
          pc_nxt       = next_pc;
          ir_valid_nxt = 1'b0;
        end else begin
          ir_nxt       = rom_fields;
          ir_pc_nxt    = pc_out;
          ir_valid_nxt = 1'b1;
          pc_nxt       = next_pc;
          if (instr_count != {CNT_W{1'b1}}) begin
            count_nxt = instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            count_nxt = instr_count;
          end
          if (at_end) begin
            state_nxt = HALTED;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        ir_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc_out      <= START_PC;
      ir          <= '0;
      ir_pc       <= 16'd0;
      ir_valid    <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_nxt;
      pc_out      <= pc_nxt;
      ir          <= ir_nxt;
      ir_pc       <= ir_pc_nxt;
      ir_valid    <= ir_valid_nxt;
      instr_count <= count_nxt;
    end
  end

  assign ir_format    = ir.format;
  assign ir_opcode    = ir.opcode;
  assign ir_sign      = ir.sign;
  assign ir_operand   = ir.operand;
  assign ir_immediate = ir.immediate;
  assign busy         = (state == RUN);
  assign halted       = (state == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: stimulus queues the expected IR presentations, a monitor
// pops and compares each cycle the DUT shows ir_valid.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        branch_en = 1'b0;
  logic        branch_rel = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        rom_format;
  logic [3:0]  rom_opcode;
  logic        rom_sign;
  logic [2:0]  rom_operand;
  logic [7:0]  rom_immediate;
  logic [15:0] pc_out;
  logic        ir_valid;
  logic [15:0] ir_pc;
  logic        ir_format;
  logic [3:0]  ir_opcode;
  logic        ir_sign;
  logic [2:0]  ir_operand;
  logic [7:0]  ir_immediate;
  logic        busy;
  logic        halted;
  logic [15:0] instr_count;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // ROM image: at address 10 the immediate is 8'hFB (-5).
  function automatic logic [8:0] rom_word(input logic [15:0] a);
    return {a[0] ^ 1'b1, a[7:0] ^ 8'hF1};
  endfunction

  logic [8:0] rw;
  assign rw            = rom_word(pc_out);
  assign rom_format    = rw[8];
  assign rom_opcode    = rw[7:4];
  assign rom_sign      = rw[3];
  assign rom_operand   = rw[2:0];
  assign rom_immediate = rw[7:0];

  fetch_sequencer #(
    .START_PC(16'd0),
    .PROG_END(16'd34),
    .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_en(branch_en), .branch_rel(branch_rel), .branch_target(branch_target),
    .rom_format(rom_format), .rom_opcode(rom_opcode), .rom_sign(rom_sign),
    .rom_operand(rom_operand), .rom_immediate(rom_immediate),
    .pc_out(pc_out), .ir_valid(ir_valid), .ir_pc(ir_pc), .ir_format(ir_format),
    .ir_opcode(ir_opcode), .ir_sign(ir_sign), .ir_operand(ir_operand),
    .ir_immediate(ir_immediate), .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [15:0] pc, input logic [15:0] cnt);
    exp_t e;
    e.pc  = pc;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic wait_ir(input logic [15:0] pc);
    bit found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (ir_valid && ir_pc == pc) found = 1'b1;
    end
    if (!found) begin
      checks++;
      $display("FAIL wait_ir: ir_pc %0h never presented, last %0h", pc, ir_pc);
    end
  endtask

  task automatic wait_halted();
    bit found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (halted) found = 1'b1;
    end
    if (!found) begin
      checks++;
      $display("FAIL wait_halted: halted never rose, pc_out %0h", pc_out);
    end
  endtask

  // Monitor: every presented instruction must match the head of the queue.
  always @(negedge clk) begin
    if (ir_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL ir_unexpected: got ir_pc %0h count %0d expected no presentation", ir_pc, instr_count);
      end else begin
        exp_t e;
        logic [8:0] w;
        e = exp_q.pop_front();
        w = rom_word(e.pc);
        chk("ir_present",
            {8'h00, ir_pc, instr_count, 7'd0, ir_format, ir_opcode, ir_sign, ir_operand, ir_immediate},
            {8'h00, e.pc, e.cnt, 7'd0, w[8], w[7:4], w[3], w[2:0], w[7:0]});
      end
    end
  end

  initial begin
    // Reset values.
    @(negedge clk);
    chk("rst_pc", {48'd0, pc_out}, 64'd0);
    chk("rst_ctl", {60'd0, ir_valid, busy, halted, 1'b0}, 64'd0);
    chk("rst_ir", {ir_pc, instr_count, 15'd0, ir_format, ir_opcode, ir_sign, ir_operand, ir_immediate}, 64'd0);
    reset = 1'b0;

    // Straight run 0..34, ending in HALTED.
    for (int i = 0; i <= 34; i++) push_exp(16'(i), 16'(i + 1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ir_valid", {63'd0, ir_valid}, 64'd0);
    chk("start_busy", {63'd0, busy}, 64'd1);
    wait_halted();
    chk("end_count", {48'd0, instr_count}, 64'd35);
    chk("end_pc", {48'd0, pc_out}, 64'd34);
    @(negedge clk);
    chk("end_bubble", {62'd0, ir_valid, halted}, 64'd1);

    // Stall at 5, relative branch at 10 back to 5, then halt with branch+stall at 7.
    for (int i = 0; i <= 5; i++) push_exp(16'(i), 16'(i + 1));
    for (int i = 0; i < 3; i++) push_exp(16'd5, 16'd6);
    for (int i = 6; i <= 10; i++) push_exp(16'(i), 16'(i + 1));
    push_exp(16'd5, 16'd12);
    push_exp(16'd6, 16'd13);
    push_exp(16'd7, 16'd14);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ir(16'd5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold", {ir_pc, pc_out, instr_count, 16'd0}, {16'd5, 16'd6, 16'd6, 16'd0});
    end
    stall = 1'b0;
    wait_ir(16'd10);
    branch_en = 1'b1;
    branch_rel = 1'b1;
    branch_target = 16'h0100;
    @(negedge clk);
    branch_en = 1'b0;
    chk("rel_branch", {47'd0, ir_valid, pc_out}, {47'd0, 1'b0, 16'd5});
    wait_ir(16'd7);
    halt_req = 1'b1;
    branch_en = 1'b1;
    branch_rel = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    branch_en = 1'b0;
    stall = 1'b0;
    chk("halt_prio", {45'd0, halted, busy, ir_valid, pc_out}, {45'd0, 1'b1, 1'b0, 1'b0, 16'd8});
    @(negedge clk);
    chk("halted_hold", {47'd0, halted, pc_out}, {47'd0, 1'b1, 16'd8});

    // Restart with an unqualified branch, absolute branch to FFFF, wrap to 0..34.
    for (int i = 0; i <= 2; i++) push_exp(16'(i), 16'(i + 1));
    push_exp(16'hFFFF, 16'd4);
    for (int i = 0; i <= 34; i++) push_exp(16'(i), 16'(i + 5));
    start = 1'b1;
    branch_en = 1'b1;
    branch_rel = 1'b0;
    branch_target = 16'h0100;
    @(negedge clk);
    start = 1'b0;
    chk("restart", {31'd0, ir_valid, instr_count, pc_out}, 64'd0);
    @(negedge clk);
    branch_en = 1'b0;
    wait_ir(16'd2);
    branch_en = 1'b1;
    branch_target = 16'hFFFF;
    @(negedge clk);
    branch_en = 1'b0;
    chk("abs_branch", {47'd0, ir_valid, pc_out}, {47'd0, 1'b0, 16'hFFFF});
    wait_ir(16'd20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halted();
    chk("wrap_end", {32'd0, instr_count, ir_pc}, {32'd0, 16'd39, 16'd34});

    // Asynchronous reset mid-run, then a short run halted by halt_req.
    @(negedge clk);
    for (int i = 0; i <= 12; i++) push_exp(16'(i), 16'(i + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ir(16'd12);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", {13'd0, ir_valid, busy, halted, pc_out, ir_pc, instr_count}, 64'd0);
    chk("async_rst_ir", {47'd0, ir_format, ir_opcode, ir_sign, ir_operand, ir_immediate}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i <= 2; i++) push_exp(16'(i), 16'(i + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ir(16'd2);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    chk("final_halt", {47'd0, halted, pc_out}, {47'd0, 1'b1, 16'd3});
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
